// File: rtl/m65c02a_bus_if.sv
// m65c02a_bus_if: bus interface between the M65C02A core and external memory.
// Registers each core bus request, stretches it by WS wait states and/or the
// external ready-low (iWait), returns registered read data, and synchronises
// the asynchronous IRQ and set-overflow inputs.
//
// Ports
//   Clk, Rst            : clock, synchronous active-high reset
//   IO_Op, AO, DO       : core request (00 none, 01 write, 10 read, 11 fetch)
//   Wait                : combinational stall request to the core
//   DI                  : registered read data to the core
//   xIRQ, SO, Clr_SO    : synchronised IRQ, latched set-overflow and its clear
//   WS, iWait, iDI      : wait states, external ready-low, external read data
//   oAO, oDO, oIO_Op    : registered address, write data and operation
//   oCyc                : bus cycle active
//   ixIRQ, iSO          : asynchronous IRQ and set-overflow inputs
//
// Build option: define M65C02A_BUS_IF_NEGEDGE_OUT_EN to re-register oAO, oDO,
// oIO_Op and oCyc on the falling clock edge for an extra half-cycle of hold.
module m65c02a_bus_if #(
   parameter int unsigned pAW   = 16,
   parameter int unsigned pDW   = 8,
   parameter int unsigned pSync = 2,
   parameter int unsigned pWSW  = 4
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic [1:0]      IO_Op,
   input  logic [pAW-1:0]  AO,
   input  logic [pDW-1:0]  DO,
   output logic            Wait,
   output logic [pDW-1:0]  DI,
   output logic            xIRQ,
   output logic            SO,
   input  logic            Clr_SO,
   input  logic [pWSW-1:0] WS,
   input  logic            iWait,
   input  logic [pDW-1:0]  iDI,
   output logic [pAW-1:0]  oAO,
   output logic [pDW-1:0]  oDO,
   output logic [1:0]      oIO_Op,
   output logic            oCyc,
   input  logic            ixIRQ,
   input  logic            iSO
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [pWSW-1:0] cnt_q, cnt_d;
   logic [pAW-1:0]  ao_q, ao_d;
   logic [pDW-1:0]  do_q, do_d;
   logic [pDW-1:0]  di_q, di_d;
   logic [1:0]      op_q, op_d;
   logic            cyc_q, cyc_d;
   logic            start;
   logic            done;
   logic [1:0]      cur_op;

   logic [pSync-1:0] irq_sync_q;
   logic [pSync-1:0] so_sync_q;
   logic             so_hist_q;
   logic             so_q;
   logic             so_set;

   assign start  = (state_q == ST_IDLE) && (IO_Op != 2'b00);
   assign done   = ((state_q == ST_WAIT) || start) && !Wait;
   assign cur_op = start ? IO_Op : op_q;

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && Wait) state_d = ST_WAIT;
         ST_WAIT: if (!Wait)         state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Stall output; the IDLE clock that starts a cycle is already the first
   // stall clock, so cnt_q counts the wait states still owed after it.
   always_comb begin
      Wait = 1'b0;
      case (state_q)
         ST_IDLE: Wait = start && ((WS != '0) || iWait);
         ST_WAIT: Wait = (cnt_q != '0) || iWait;
         default: Wait = 1'b0;
      endcase
      if (Rst) Wait = 1'b0;
   end

   // Request capture, wait-state counter and read-data return
   always_comb begin
      cnt_d = cnt_q;
      ao_d  = ao_q;
      do_d  = do_q;
      op_d  = op_q;
      cyc_d = cyc_q;
      di_d  = di_q;
      if (state_q == ST_IDLE) begin
         if (start) begin
            ao_d  = AO;
            do_d  = DO;
            op_d  = IO_Op;
            cyc_d = 1'b1;
            cnt_d = (WS != '0) ? WS - pWSW'(1) : '0;
         end else begin
            op_d  = 2'b00;
            cyc_d = 1'b0;
         end
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - pWSW'(1);
      end
      if (done && cur_op[1]) di_d = iDI;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
         ao_q  <= '0;
         do_q  <= '0;
         op_q  <= 2'b00;
         cyc_q <= 1'b0;
         di_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         ao_q  <= ao_d;
         do_q  <= do_d;
         op_q  <= op_d;
         cyc_q <= cyc_d;
         di_q  <= di_d;
      end
   end

   // Synchronisers and set-overflow latch; set wins over a same-clock clear
   assign so_set = so_sync_q[pSync-1] & ~so_hist_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         irq_sync_q <= '0;
         so_sync_q  <= '0;
         so_hist_q  <= 1'b0;
         so_q       <= 1'b0;
      end else begin
         irq_sync_q <= {irq_sync_q[pSync-2:0], ixIRQ};
         so_sync_q  <= {so_sync_q[pSync-2:0], iSO};
         so_hist_q  <= so_sync_q[pSync-1];
         if (so_set)      so_q <= 1'b1;
         else if (Clr_SO) so_q <= 1'b0;
      end
   end

   assign DI   = di_q;
   assign xIRQ = irq_sync_q[pSync-1];
   assign SO   = so_q;

`ifdef M65C02A_BUS_IF_NEGEDGE_OUT_EN
   // Half-cycle output hold; reset reaches these through the source registers
   always_ff @(negedge Clk) begin
      oAO    <= ao_q;
      oDO    <= do_q;
      oIO_Op <= op_q;
      oCyc   <= cyc_q;
   end
`else
   assign oAO    = ao_q;
   assign oDO    = do_q;
   assign oIO_Op = op_q;
   assign oCyc   = cyc_q;
`endif

endmodule

// File: tb/tb_m65c02a_bus_if.sv
// Self-checking bench for m65c02a_bus_if: directed and random bus cycles
// feed a scoreboard queue; a negedge monitor pops and compares completions,
// and a delay-line model checks xIRQ and SO every clock.
module tb_m65c02a_bus_if;

   localparam int P_SYNC = 2;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [1:0]  IO_Op = 2'b00;
   logic [15:0] AO = '0;
   logic [7:0]  DO = '0;
   logic        Wait;
   logic [7:0]  DI;
   logic        xIRQ;
   logic        SO;
   logic        Clr_SO = 1'b0;
   logic [3:0]  WS = '0;
   logic        iWait = 1'b0;
   logic [7:0]  iDI = '0;
   logic [15:0] oAO;
   logic [7:0]  oDO;
   logic [1:0]  oIO_Op;
   logic        oCyc;
   logic        ixIRQ = 1'b0;
   logic        iSO = 1'b0;

   m65c02a_bus_if #(.pAW(16), .pDW(8), .pSync(P_SYNC), .pWSW(4)) dut (
      .Clk(Clk), .Rst(Rst), .IO_Op(IO_Op), .AO(AO), .DO(DO), .Wait(Wait),
      .DI(DI), .xIRQ(xIRQ), .SO(SO), .Clr_SO(Clr_SO), .WS(WS), .iWait(iWait),
      .iDI(iDI), .oAO(oAO), .oDO(oDO), .oIO_Op(oIO_Op), .oCyc(oCyc),
      .ixIRQ(ixIRQ), .iSO(iSO)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] ao;
      logic [7:0]  dout;
      logic [1:0]  op;
      logic [7:0]  di;
      int          stall;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  di_model = '0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          side_rand = 1'b0;

   bit          irq_hist[$];
   bit          so_hist[$];
   bit          so_m = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic finish_sim();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   // Reference model for the synchronised IRQ and the set-overflow latch
   always @(posedge Clk) begin
      bit a, b;
      int n;
      if (Rst) begin
         irq_hist.delete();
         so_hist.delete();
         so_m = 1'b0;
      end else begin
         n = so_hist.size();
         a = (n >= P_SYNC)     ? so_hist[n - P_SYNC]     : 1'b0;
         b = (n >= P_SYNC + 1) ? so_hist[n - P_SYNC - 1] : 1'b0;
         if (a && !b)     so_m = 1'b1;
         else if (Clr_SO) so_m = 1'b0;
         so_hist.push_back(iSO);
         irq_hist.push_back(ixIRQ);
         while (so_hist.size() > P_SYNC + 2)  void'(so_hist.pop_front());
         while (irq_hist.size() > P_SYNC + 2) void'(irq_hist.pop_front());
      end
   end

   // Monitor: completion detection, scoreboard compare, idle and sync checks
   always @(negedge Clk) begin
      static bit pend = 1'b0;
      static bit prev_idle = 1'b0;
      static int stall = 0;
      static int done_stall = 0;
      exp_t e;
      bit   irq_e;
      int   n;
      if (Rst) begin
         pend = 1'b0;
         prev_idle = 1'b0;
         stall = 0;
      end else begin
         if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_completion: oAO %0h (t=%0t)", oAO, $time);
            end else begin
               e = exp_q.pop_front();
               chk("txn_oAO", 32'(oAO), 32'(e.ao));
               chk("txn_oDO", 32'(oDO), 32'(e.dout));
               chk("txn_oIO_Op", 32'(oIO_Op), 32'(e.op));
               chk("txn_oCyc", 32'(oCyc), 32'(1));
               chk("txn_DI", 32'(DI), 32'(e.di));
               chk("txn_stall", 32'(done_stall), 32'(e.stall));
            end
         end
         if (prev_idle) chk("idle_oCyc", 32'(oCyc), 32'(0));
         prev_idle = (IO_Op == 2'b00);
         if (IO_Op == 2'b00) chk("idle_Wait", 32'(Wait), 32'(0));
         else if (Wait) stall++;
         else begin
            pend = 1'b1;
            done_stall = stall;
            stall = 0;
         end
      end
      n = irq_hist.size();
      irq_e = (n >= P_SYNC) ? irq_hist[n - P_SYNC] : 1'b0;
      chk("xIRQ", 32'(xIRQ), 32'(irq_e));
      chk("SO", 32'(SO), 32'(so_m));
   end

   // Background activity on the asynchronous inputs
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (side_rand) begin
            ixIRQ  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) iSO = ~iSO;
            Clr_SO = ($urandom_range(0, 4) == 0);
         end
      end
   end

   // One bus cycle; the core holds a request until Wait drops
   task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                          input int ws, input int nw, input logic [7:0] rd);
      exp_t e;
      int   k_done;
      bit   done;
      k_done = (ws > nw) ? ws : nw;
      if (op[1]) di_model = rd;
      e.ao = a;
      e.dout = d;
      e.op = op;
      e.di = di_model;
      e.stall = k_done;
      exp_q.push_back(e);
      WS = 4'(ws);
      IO_Op = op;
      AO = a;
      DO = d;
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
         if (k > 0) begin
            @(posedge Clk);
            #1;
            AO = 16'($urandom);
            DO = 8'($urandom);
            IO_Op = 2'($urandom_range(1, 3));
         end
         iWait = (k < nw);
         iDI = (k == k_done) ? rd : ~rd;
         @(negedge Clk);
         if (!Wait) done = 1'b1;
         else if (k > 0) begin
            chk("stall_oAO", 32'(oAO), 32'(a));
            chk("stall_oDO", 32'(oDO), 32'(d));
            chk("stall_oCyc", 32'(oCyc), 32'(1));
         end
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL txn_timeout: Wait still %0b after 64 clocks, want 0", Wait);
         finish_sim();
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         IO_Op = 2'b00;
         AO = 16'($urandom);
         DO = 8'($urandom);
         iWait = 1'($urandom_range(0, 1));
         iDI = 8'($urandom);
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      repeat (3) step();
      chk("rst_Wait", 32'(Wait), 32'(0));
      chk("rst_DI", 32'(DI), 32'(0));
      chk("rst_oAO", 32'(oAO), 32'(0));
      chk("rst_oDO", 32'(oDO), 32'(0));
      chk("rst_oIO_Op", 32'(oIO_Op), 32'(0));
      chk("rst_oCyc", 32'(oCyc), 32'(0));
      chk("rst_xIRQ", 32'(xIRQ), 32'(0));
      chk("rst_SO", 32'(SO), 32'(0));
      Rst = 1'b0;
      idle(2);

      run_txn(2'b10, 16'h1234, 8'h00, 0, 0, 8'hA5);
      idle(2);
      run_txn(2'b01, 16'h2000, 8'h5A, 3, 0, 8'h00);
      idle(1);
      run_txn(2'b11, 16'h3000, 8'h00, 1, 4, 8'h3C);
      idle(1);
      run_txn(2'b10, 16'h0100, 8'h00, 0, 0, 8'h61);
      run_txn(2'b10, 16'h0101, 8'h00, 0, 0, 8'h62);
      idle(1);
      run_txn(2'b10, 16'hFFFF, 8'h00, 15, 2, 8'hC3);
      run_txn(2'b01, 16'h4000, 8'h99, 0, 3, 8'h00);
      idle(1);

      side_rand = 1'b1;
      for (int t = 0; t < 150; t++) begin
         int ws, nw;
         ws = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
         nw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
         run_txn(2'($urandom_range(1, 3)), 16'($urandom), 8'($urandom), ws, nw, 8'($urandom));
         idle(int'($urandom_range(0, 2)));
      end
      side_rand = 1'b0;
      Clr_SO = 1'b0;
      iSO = 1'b1;
      idle(2);

      // Reset in the middle of a WS=5 read, iSO held high through it
      run_txn(2'b10, 16'h5555, 8'h00, 0, 0, 8'h77);
      WS = 4'd5;
      IO_Op = 2'b10;
      AO = 16'hBEEF;
      iWait = 1'b0;
      iDI = 8'h11;
      step();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      IO_Op = 2'b00;
      di_model = '0;
      chk("abort_Wait", 32'(Wait), 32'(0));
      chk("abort_oCyc", 32'(oCyc), 32'(0));
      chk("abort_oAO", 32'(oAO), 32'(0));
      chk("abort_oIO_Op", 32'(oIO_Op), 32'(0));
      chk("abort_DI", 32'(DI), 32'(0));
      chk("abort_SO", 32'(SO), 32'(0));
      step();
      chk("so_release_1", 32'(SO), 32'(0));
      step();
      chk("so_release_2", 32'(SO), 32'(0));
      step();
      chk("so_release_3", 32'(SO), 32'(1));
      chk("abort_DI_hold", 32'(DI), 32'(0));
      chk("abort_oCyc_hold", 32'(oCyc), 32'(0));

      // Level-high iSO sets once; a lone clear then sticks
      repeat (3) step();
      Clr_SO = 1'b1;
      step();
      Clr_SO = 1'b0;
      chk("so_clr", 32'(SO), 32'(0));
      repeat (4) step();
      chk("so_level_once", 32'(SO), 32'(0));

      // New edge with a clear on the same clock: set wins
      iSO = 1'b0;
      repeat (5) step();
      iSO = 1'b1;
      step();
      step();
      chk("so_edge_2", 32'(SO), 32'(0));
      Clr_SO = 1'b1;
      step();
      Clr_SO = 1'b0;
      chk("so_set_wins", 32'(SO), 32'(1));
      Clr_SO = 1'b1;
      step();
      Clr_SO = 1'b0;
      chk("so_clr_alone", 32'(SO), 32'(0));

      run_txn(2'b11, 16'h0F0F, 8'h00, 2, 0, 8'hE7);
      idle(3);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      finish_sim();
   end

   initial begin
      #2000000;
      n_chk++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_sim();
   end

endmodule

// File: doc/m65c02a_bus_if.md
M65C02A_BUS_IF -- requirements
Module: m65c02a_bus_if

Interface
- REQ-001 SHALL have parameter pAW, default 16: address width.
- REQ-002 SHALL have parameter pDW, default 8: data width.
- REQ-003 SHALL have parameter pSync, default 2, range 2..4: synchroniser depth for ixIRQ and iSO.
- REQ-004 SHALL have parameter pWSW, default 4: wait-state counter width.
- REQ-005 SHALL have one clock and a synchronous, active-high reset:
  - Clk  in  1  system clock; all state changes on rising edge.
  - Rst  in  1  synchronous reset, active-high.
- REQ-006 SHALL have these core-side ports:
  - IO_Op  in  2  00 none, 01 write, 10 read, 11 fetch.
  - AO  in  pAW  core address.
  - DO  in  pDW  core write data.
  - Wait  out  1  stall request to core.
  - DI  out  pDW  registered read data to core.
  - xIRQ  out  1  synchronised IRQ.
  - SO  out  1  latched set-overflow request.
  - Clr_SO  in  1  SO acknowledge from core.
- REQ-007 SHALL have these external-side ports:
  - WS  in  pWSW  wait states per cycle; quasi-static.
  - iWait  in  1  external ready-low.
  - iDI  in  pDW  external read data.
  - oAO  out  pAW  address.
  - oDO  out  pDW  write data.
  - oIO_Op  out  2  registered IO_Op.
  - oCyc  out  1  bus cycle active.
  - ixIRQ  in  1  asynchronous IRQ.
  - iSO  in  1  asynchronous set-overflow.

Function
- REQ-008 FSM SHALL have states IDLE and WAIT.
- REQ-009 IDLE, IO_Op != 00:
  - SHALL capture AO, DO, IO_Op into oAO, oDO, oIO_Op.
  - SHALL assert oCyc.
  - SHALL load the counter with WS.
- REQ-010 IDLE, IO_Op != 00, WS == 0 and iWait == 0: cycle SHALL complete in the same clock.
  - Wait = 0.
  - DI SHALL capture iDI at that edge (read/fetch only).
  - SHALL stay in IDLE.
- REQ-011 IDLE, IO_Op != 00, WS != 0 or iWait == 1: Wait SHALL be 1 combinationally; FSM SHALL go to WAIT.
- REQ-012 WAIT:
  - Counter SHALL decrement by 1 per clock, saturating at 0.
  - Wait SHALL equal NOT (counter == 0 AND iWait == 0).
  - When Wait == 0: DI SHALL capture iDI on read/fetch, and FSM SHALL return to IDLE.
- REQ-013 Total stall SHALL be max(WS, clocks until iWait == 0) cycles; WS = 2^pWSW-1 SHALL be legal without wrap.
- REQ-014 Back-to-back: a new non-zero IO_Op in the IDLE cycle following completion SHALL start a new cycle with no idle gap.
- REQ-015 IO_Op == 00 in IDLE SHALL deassert oCyc, hold oAO/oDO/DI, and leave Wait = 0.
- REQ-016 IO_Op changes while in WAIT SHALL be ignored until completion.
- REQ-017 DI SHALL hold its value on write cycles.
- REQ-018 ixIRQ SHALL pass through pSync flops to xIRQ; latency SHALL be pSync clocks.
- REQ-019 iSO SHALL pass through pSync flops.
- REQ-020 A synchronised 0->1 edge of iSO SHALL set SO.
- REQ-021 Clr_SO SHALL clear SO.
- REQ-022 If a set and Clr_SO occur in the same clock, set SHALL win.
- REQ-023 A level-high iSO SHALL produce exactly one set.

Reset
- REQ-024 On Rst = 1 at a clock edge, all of the following SHALL take effect:
  - FSM = IDLE, counter = 0, Wait = 0.
  - oAO = 0, oDO = 0, oIO_Op = 00, oCyc = 0, DI = 0.
  - All synchroniser flops = 0, xIRQ = 0, SO = 0.
- REQ-025 Reset during WAIT SHALL abort the cycle; FSM = IDLE, no DI update.
- REQ-026 While Rst is high, IO_Op SHALL be ignored.
- REQ-027 Reset SHALL set the iSO edge-detector history to 0, so iSO held high through reset SHALL set SO once pSync+1 clocks after release.

Configuration
- REQ-028 Macro M65C02A_BUS_IF_NEGEDGE_OUT_EN:
  - Defined: oAO, oDO, oIO_Op, oCyc SHALL be re-registered on the falling edge of Clk, adding a half-cycle of output hold. Reset still applies through the rising-edge source registers and appears at the outputs by the next falling edge.
  - Undefined: these outputs SHALL come directly from the rising-edge registers.
  - Internal cycle timing SHALL be identical in both builds.

Verification
- REQ-029 Read, WS=0, iWait=0: IO_Op=10, AO=16'h1234, iDI=8'hA5 -> Wait=0; next clock DI=8'hA5, oAO=16'h1234, oIO_Op=10.
- REQ-030 Write, WS=3, iWait=0: IO_Op=01, DO=8'h5A -> Wait high exactly 3 clocks; oDO=8'h5A throughout; DI unchanged.
- REQ-031 Fetch, WS=1, iWait high 4 clocks: IO_Op=11 -> Wait high 4 clocks; DI captures iDI on the first clock with iWait=0.
- REQ-032 Rst asserted 1 clock into a WS=5 read -> next clock: Wait=0, oCyc=0, oAO=0, DI=0; the read is not completed.
- REQ-033 iSO rises, pSync=2 -> SO=1 after 3 clocks. Clr_SO pulsed on the same clock as a new iSO edge -> SO stays 1. Clr_SO alone -> SO=0.
- REQ-034 Back-to-back reads, WS=0, AO=16'h0100 then 16'h0101 -> consecutive completions; oCyc continuously 1; Wait never asserted.
